// File: rtl/ntt_pkg.sv
// Shared types and elaboration-time helpers for the iterative NTT engine.
package ntt_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StScale, StDone} ntt_state_e;

  // Ceiling log2, usable at elaboration time.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Exact modular product; operands are below 2^32, so the product fits in 64 bits.
  function automatic logic [63:0] modmul(input logic [63:0] x, input logic [63:0] y,
                                         input logic [63:0] q);
    return (x * y) % q;
  endfunction

  // Operands must already be in [0, q-1].
  function automatic logic [63:0] modadd(input logic [63:0] x, input logic [63:0] y,
                                         input logic [63:0] q);
    logic [63:0] s;
    s = x + y;
    return (s >= q) ? s - q : s;
  endfunction

  // Operands must already be in [0, q-1]; a negative difference wraps by adding q.
  function automatic logic [63:0] modsub(input logic [63:0] x, input logic [63:0] y,
                                         input logic [63:0] q);
    return (x >= y) ? x - y : x + q - y;
  endfunction

  function automatic int unsigned bitrev(input int unsigned m, input int unsigned bits);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < bits; i++) begin
      r = (r << 1) | ((m >> i) & 1);
    end
    return r;
  endfunction

  function automatic logic [63:0] pow_mod(input logic [63:0] base, input int unsigned e,
                                          input logic [63:0] q);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned i = 0; i < e; i++) begin
      r = modmul(r, base, q);
    end
    return r;
  endfunction

  // Entry m of a bit-reversed power table: root^bitrev(m) mod q.
  function automatic logic [63:0] twiddle_at(input logic [63:0] root, input int unsigned m,
                                             input int unsigned logd, input logic [63:0] q);
    return pow_mod(root, bitrev(m, logd), q);
  endfunction

  // Butterfly span of stage s: shrinking for CT (forward), growing for GS (inverse).
  function automatic int unsigned stage_jump(input int unsigned s, input logic inv,
                                             input int unsigned d);
    return inv ? (32'd1 << s) : (d >> (s + 1));
  endfunction

  // Lower lane of butterfly j when pairs are spaced jump apart.
  function automatic int unsigned pair_lo(input int unsigned j, input int unsigned jump);
    return (j / jump) * 2 * jump + (j % jump);
  endfunction

  // Table index of the twiddle used by butterfly j in stage s.
  function automatic int unsigned tw_index(input int unsigned j, input int unsigned s,
                                           input logic inv, input int unsigned d);
    int unsigned jump;
    int unsigned grp;
    jump = stage_jump(s, inv, d);
    grp  = j / jump;
    return inv ? (d / (2 * jump) + grp) : (grp + (32'd1 << s));
  endfunction

endpackage

// File: rtl/ntt_butterfly.sv
// One modular butterfly: Cooley-Tukey when inv = 0, Gentleman-Sande when inv = 1.
module ntt_butterfly
  import ntt_pkg::*;
#(
  parameter int unsigned N = 17,
  parameter int unsigned Q = 65537
) (
  input  logic [N-1:0] u,
  input  logic [N-1:0] v,
  input  logic [N-1:0] w,
  input  logic         inv,
  output logic [N-1:0] x_lo,
  output logic [N-1:0] x_hi
);

  localparam logic [63:0] QL = 64'(Q);

  logic [N-1:0] t;
  logic [N-1:0] diff;

  // CT: (u + wv, u - wv); GS: (u + v, (u - v)w).
  always_comb begin
    t    = N'(modmul(64'(v), 64'(w), QL));
    diff = N'(modsub(64'(u), 64'(v), QL));
    if (inv) begin
      x_lo = N'(modadd(64'(u), 64'(v), QL));
      x_hi = N'(modmul(64'(diff), 64'(w), QL));
    end else begin
      x_lo = N'(modadd(64'(u), 64'(t), QL));
      x_hi = N'(modsub(64'(u), 64'(t), QL));
    end
  end

endmodule

// File: rtl/ntt_iter_core.sv
// Iterative NTT/INTT engine: one butterfly stage per cycle, handshaked in and out.
module ntt_iter_core
  import ntt_pkg::*;
#(
  parameter int unsigned N       = 17,
  parameter int unsigned D       = 8,
  parameter int unsigned Q       = 65537,
  parameter int unsigned PSI     = 4,
  parameter int unsigned PSI_INV = 49153,
  parameter int unsigned D_INV   = 57345
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           in_inv,
  input  logic [D*N-1:0] a,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [D*N-1:0] b,
  output logic           busy
);

  localparam int unsigned LOGD = clog2(D);
  localparam int unsigned KW   = clog2(LOGD) + 1;
  localparam int unsigned HALF = D / 2;

  ntt_state_e    state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic          inv_q, inv_d;
  logic [N-1:0]  lane_q [D];
  logic [N-1:0]  lane_d [D];

  // Twiddle tables, constant after elaboration. Entry 0 is never addressed.
  logic [N-1:0] psi_rev     [D];
  logic [N-1:0] psi_inv_rev [D];

  for (genvar m = 0; m < D; m++) begin : g_tw
    assign psi_rev[m]     = N'(twiddle_at(64'(PSI), m, LOGD, 64'(Q)));
    assign psi_inv_rev[m] = N'(twiddle_at(64'(PSI_INV), m, LOGD, 64'(Q)));
  end

  // Per-stage operand selections and per-stage write-back images.
  logic [N-1:0] stage_u [LOGD][HALF];
  logic [N-1:0] stage_v [LOGD][HALF];
  logic [N-1:0] stage_w [LOGD][HALF];
  logic [N-1:0] fwd_res [LOGD][D];
  logic [N-1:0] inv_res [LOGD][D];

  // Shared butterfly array, fed by the stage selected by k_q.
  logic [N-1:0] bf_u  [HALF];
  logic [N-1:0] bf_v  [HALF];
  logic [N-1:0] bf_w  [HALF];
  logic [N-1:0] bf_lo [HALF];
  logic [N-1:0] bf_hi [HALF];

  for (genvar j = 0; j < HALF; j++) begin : g_bf
    ntt_butterfly #(
      .N(N),
      .Q(Q)
    ) u_bf (
      .u    (bf_u[j]),
      .v    (bf_v[j]),
      .w    (bf_w[j]),
      .inv  (inv_q),
      .x_lo (bf_lo[j]),
      .x_hi (bf_hi[j])
    );
  end

  // Lane-pair wiring for every stage, both modes; pairs partition the lanes.
  for (genvar s = 0; s < LOGD; s++) begin : g_stage
    for (genvar j = 0; j < HALF; j++) begin : g_pair
      localparam int unsigned FJ  = stage_jump(s, 1'b0, D);
      localparam int unsigned FLO = pair_lo(j, FJ);
      localparam int unsigned FTW = tw_index(j, s, 1'b0, D);
      localparam int unsigned IJ  = stage_jump(s, 1'b1, D);
      localparam int unsigned ILO = pair_lo(j, IJ);
      localparam int unsigned ITW = tw_index(j, s, 1'b1, D);

      assign stage_u[s][j] = inv_q ? lane_q[ILO] : lane_q[FLO];
      assign stage_v[s][j] = inv_q ? lane_q[ILO+IJ] : lane_q[FLO+FJ];
      assign stage_w[s][j] = inv_q ? psi_inv_rev[ITW] : psi_rev[FTW];

      assign fwd_res[s][FLO]    = bf_lo[j];
      assign fwd_res[s][FLO+FJ] = bf_hi[j];
      assign inv_res[s][ILO]    = bf_lo[j];
      assign inv_res[s][ILO+IJ] = bf_hi[j];
    end
  end

  // Steer the current stage's operands into the butterflies.
  always_comb begin
    for (int j = 0; j < HALF; j++) begin
      bf_u[j] = '0;
      bf_v[j] = '0;
      bf_w[j] = '0;
    end
    for (int s = 0; s < LOGD; s++) begin
      if (k_q == KW'(s)) begin
        for (int j = 0; j < HALF; j++) begin
          bf_u[j] = stage_u[s][j];
          bf_v[j] = stage_v[s][j];
          bf_w[j] = stage_w[s][j];
        end
      end
    end
  end

  // Next-state logic: load, stage sequencing, final scale and output handshake.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    inv_d   = inv_q;
    for (int i = 0; i < D; i++) begin
      lane_d[i] = lane_q[i];
    end

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          for (int i = 0; i < D; i++) begin
            // Lanes may be up to 2Q-1, so one conditional subtract suffices.
            lane_d[i] = (a[N*i +: N] >= N'(Q)) ? a[N*i +: N] - N'(Q) : a[N*i +: N];
          end
          inv_d   = in_inv;
          k_d     = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        for (int s = 0; s < LOGD; s++) begin
          if (k_q == KW'(s)) begin
            for (int i = 0; i < D; i++) begin
              lane_d[i] = inv_q ? inv_res[s][i] : fwd_res[s][i];
            end
          end
        end
        if (k_q == KW'(LOGD - 1)) begin
          state_d = inv_q ? StScale : StDone;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      StScale: begin
        for (int i = 0; i < D; i++) begin
          lane_d[i] = N'(modmul(64'(lane_q[i]), 64'(D_INV), 64'(Q)));
        end
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, stage counter, mode and lane registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      k_q     <= '0;
      inv_q   <= 1'b0;
      for (int i = 0; i < D; i++) begin
        lane_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      inv_q   <= inv_d;
      for (int i = 0; i < D; i++) begin
        lane_q[i] <= lane_d[i];
      end
    end
  end

  // Outputs decode from state or come straight from the lane registers.
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    busy      = (state_q == StRun) || (state_q == StScale);
    for (int i = 0; i < D; i++) begin
      b[N*i +: N] = lane_q[i];
    end
  end

endmodule

// File: tb/tb_ntt_iter_core.sv
// Directed and round-trip checks of ntt_iter_core against an O(D^2) reference NTT.
module tb_ntt_iter_core;

  localparam int unsigned N       = 17;
  localparam int unsigned D       = 8;
  localparam int unsigned LOGD    = 3;
  localparam int unsigned Q       = 65537;
  localparam int unsigned PSI     = 4;
  localparam int unsigned W       = D * N;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         in_inv;
  logic [W-1:0] a;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] b;
  logic         busy;

  int n_vec;
  int n_miss;

  ntt_iter_core #(
    .N       (N),
    .D       (D),
    .Q       (Q),
    .PSI     (PSI),
    .PSI_INV (49153),
    .D_INV   (57345)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_inv    (in_inv),
    .a         (a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .b         (b),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic int unsigned brv(input int unsigned m);
    int unsigned r;
    r = 0;
    for (int i = 0; i < LOGD; i++) r = (r << 1) | ((m >> i) & 1);
    return r;
  endfunction

  function automatic longint unsigned powm(input longint unsigned base, input int unsigned e);
    longint unsigned r;
    r = 1;
    for (int unsigned i = 0; i < e; i++) r = (r * base) % Q;
    return r;
  endfunction

  function automatic logic [W-1:0] reduce_vec(input logic [W-1:0] x);
    logic [W-1:0] r;
    for (int l = 0; l < D; l++) r[N*l +: N] = N'(64'(x[N*l +: N]) % 64'(Q));
    return r;
  endfunction

  // Negacyclic NTT, output in bit-reversed order: X[j] = sum_k x[k] psi^((2 brv(j)+1) k).
  function automatic logic [W-1:0] golden_ntt(input logic [W-1:0] x);
    logic [W-1:0]    r;
    longint unsigned acc;
    longint unsigned xl;
    for (int j = 0; j < D; j++) begin
      acc = 0;
      for (int k = 0; k < D; k++) begin
        xl  = 64'(x[N*k +: N]) % 64'(Q);
        acc = (acc + xl * powm(PSI, ((2 * brv(j) + 1) * k) % (2 * D))) % Q;
      end
      r[N*j +: N] = N'(acc);
    end
    return r;
  endfunction

  // Present one vector with out_ready high; returns the result after checking latency.
  task automatic run_vec(input logic [W-1:0] vec, input logic inv, input string tag,
                         output logic [W-1:0] res);
    int lat;
    check_eq({tag, "_ready"}, W'(in_ready), W'(1));
    a        = vec;
    in_inv   = inv;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a        = ~vec;
    in_inv   = ~inv;
    check_eq({tag, "_busy"}, W'(busy), W'(1));
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, "_lat"}, W'(lat), inv ? W'(4) : W'(3));
    res = b;
    @(posedge clk); #1;
  endtask

  logic [W-1:0] ones, impulse, v, f, r, held, v2;
  int           lat;
  int           lv [D];

  initial begin
    n_vec     = 0;
    n_miss    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_inv    = 1'b0;
    a         = '0;
    out_ready = 1'b1;
    for (int l = 0; l < D; l++) begin
      ones[N*l +: N]    = N'(1);
      impulse[N*l +: N] = (l == 0) ? N'(1) : N'(0);
    end

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_eq("rst_in_ready", W'(in_ready), W'(1));
    check_eq("rst_out_valid", W'(out_valid), W'(0));
    check_eq("rst_b", b, '0);
    check_eq("rst_busy", W'(busy), W'(0));

    run_vec(impulse, 1'b0, "fwd_imp", f);
    check_eq("fwd_imp_b", f, ones);

    run_vec(ones, 1'b1, "inv_ones", r);
    check_eq("inv_ones_b", r, impulse);

    // Round trips; vector 0 exercises the load-reduction boundaries.
    lv = '{0, 1, Q - 1, Q, Q + 1, 131071, 65536, 12345};
    for (int i = 0; i < 200; i++) begin
      for (int l = 0; l < D; l++) begin
        v[N*l +: N] = (i == 0) ? N'(lv[l]) : N'($urandom_range(0, 131071));
      end
      run_vec(v, 1'b0, "rt_fwd", f);
      check_eq("rt_fwd_b", f, golden_ntt(v));
      run_vec(f, 1'b1, "rt_inv", r);
      check_eq("rt_inv_b", r, reduce_vec(v));
    end

    // Back-pressure: DONE must hold while out_ready is low.
    for (int l = 0; l < D; l++) begin
      v[N*l +: N]  = N'(l * 1000 + 7);
      v2[N*l +: N] = N'(65536 - l * 3);
    end
    out_ready = 1'b0;
    a         = v;
    in_inv    = 1'b0;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat      = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq("bp_lat", W'(lat), W'(3));
    check_eq("bp_b", b, golden_ntt(v));
    held = b;
    a    = v2;
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 2 == 0);
      @(posedge clk); #1;
      check_eq("bp_hold_valid", W'(out_valid), W'(1));
      check_eq("bp_hold_b", b, held);
      check_eq("bp_hold_ready", W'(in_ready), W'(0));
    end
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("bp_hs_ready", W'(in_ready), W'(1));
    check_eq("bp_hs_busy", W'(busy), W'(0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("bp_acc_busy", W'(busy), W'(1));
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq("bp2_lat", W'(lat), W'(3));
    check_eq("bp2_b", b, golden_ntt(v2));
    @(posedge clk); #1;

    // Reset sampled at edge 2 of RUN.
    a        = v;
    in_inv   = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("mid_rst_ready", W'(in_ready), W'(1));
    check_eq("mid_rst_busy", W'(busy), W'(0));
    check_eq("mid_rst_valid", W'(out_valid), W'(0));
    check_eq("mid_rst_b", b, '0);
    run_vec(impulse, 1'b0, "post_rst", f);
    check_eq("post_rst_b", f, ones);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ntt_iter_core.md
# ntt_iter_core

Iterative, handshaked NTT/INTT engine for D coefficients of N bits modulo Q. A parallel vector is accepted on a valid/ready input, the transform runs one butterfly stage per cycle, and the result is held on a valid/ready output until it is consumed. Forward mode uses Cooley-Tukey stages. Inverse mode uses Gentleman-Sande stages plus a D⁻¹ scale, so INTT(NTT(x)) = x. The block is the sequenced, mode-capable successor to the flat NTT datapath and sits between the coefficient buffer and the pointwise-multiply unit.

## Interface
- N, 17: coefficient width in bits. Requires 2^N ≤ 2Q.
- D, 8: transform size. Power of two, ≥ 2.
- Q, 65537: prime modulus. Requires 2D | (Q−1).
- PSI, 4: primitive 2D-th root of unity mod Q.
- PSI_INV, 49153: PSI⁻¹ mod Q.
- D_INV, 57345: D⁻¹ mod Q.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input vector valid.
- in_ready  out  1  block can accept a vector.
- in_inv  in  1  0 = forward NTT, 1 = inverse. Sampled with the data.
- a  in  D*N  input coefficients; lane i is a[N*(i+1)-1:N*i].
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- b  out  D*N  result coefficients, same lane packing as a.
- busy  out  1  high in RUN or SCALE.

## Operation
- States are IDLE, RUN, SCALE and DONE. Stage counter k has width clog2(clog2(D))+1.
- IDLE:
  - in_ready = 1.
  - When in_valid is high, capture a into the lane registers. Reduce each lane once on capture: if x ≥ Q then x − Q.
  - Latch in_inv and set k = 0, then go to RUN.
- RUN, forward mode:
  - Stage k uses jump = D >> (k+1).
  - For each lane pair (i, i+jump) with i/jump even, u = x[i] and v = x[i+jump].
  - Twiddle is w = psi_rev[(i/(2·jump)) + 2^k], where psi_rev[m] = PSI^bitrev_log2D(m) mod Q.
  - Update: x[i] = (u + w·v) mod Q and x[i+jump] = (u − w·v) mod Q.
- RUN, inverse mode:
  - Stage k uses jump = 1 << k.
  - Update: x[i] = (u + v) mod Q and x[i+jump] = ((u − v)·w) mod Q.
  - Twiddle is w = psi_inv_rev[(D/(2·jump)) + i/(2·jump)], built from PSI_INV.
- Leaving RUN:
  - After stage log2(D)−1, forward mode goes to DONE and inverse mode goes to SCALE.
- SCALE:
  - Multiply every lane by D_INV mod Q, then go to DONE.
- DONE:
  - out_valid = 1 and b holds the lane registers.
  - When out_ready is high, go to IDLE.
- Arithmetic:
  - Products are 2N bits wide and reduced exactly mod Q.
  - Subtraction adds Q when the difference is negative.
  - All lane values stay in [0, Q−1] after the load reduction.
- b is driven from the lane registers at all times. It is meaningful only while out_valid is high.
- Boundary conditions:
  - in_valid while not in IDLE is ignored. in_ready is 0 in RUN, SCALE and DONE.
  - in_inv and a changes after acceptance have no effect on the running transform.
  - With out_ready held low, DONE holds indefinitely; b and out_valid stay stable.
  - rst at any cycle, including mid-RUN: the next state is IDLE.
  - There is no overlap: the next vector is accepted no earlier than the cycle after the DONE handshake.

## Timing
- Reset values:
  - state = IDLE, so in_ready = 1.
  - out_valid = 0, busy = 0.
  - Lane registers = 0, so b = 0.
  - k = 0 and the latched mode = 0.
- Cycle numbering: the acceptance edge is cycle 0.
  - RUN occupies edges 1 to log2(D).
  - out_valid rises after edge log2(D) for forward mode and after edge log2(D)+1 for inverse mode.
  - For D = 8 this is 3 cycles forward and 4 cycles inverse.
- Minimum initiation interval: log2(D)+2 cycles forward and log2(D)+3 cycles inverse.
- All outputs are registered or decoded from state only. There is no combinational path from in_valid or out_ready to any output.

## Structure
- Package ntt_pkg holds:
  - the state enum;
  - a clog2 helper;
  - functions modmul(x, y, Q), modadd, modsub and bitrev;
  - the elaboration-time functions that build the psi_rev and psi_inv_rev tables from PSI, PSI_INV, Q and D. No ROM files.
- Sub-module ntt_butterfly(N, Q):
  - inputs u, v, w and inv; outputs x_lo and x_hi;
  - CT when inv = 0, GS when inv = 1.
  - D/2 instances are driven through per-stage lane-pair muxes indexed by k.
- Scaling reuses modmul per lane.

## Test plan
- Reset, then idle: in_ready = 1, out_valid = 0, b = 0, busy = 0.
- Forward impulse, D=8, Q=65537:
  - Stimulus: a = [1,0,0,0,0,0,0,0] with in_inv = 0, out_ready = 1.
  - Required: out_valid 3 cycles after acceptance, b = all 1.
- Inverse of all-ones:
  - Stimulus: a = all 1 with in_inv = 1.
  - Required: out_valid 4 cycles after acceptance, b = [1,0,0,0,0,0,0,0].
- Round trip and load reduction:
  - Stimulus: 200 random vectors with lanes in [0, 2^17−1], forward then the result fed back inverse.
  - Required: the output equals the input reduced mod 65537 and matches the bench golden model.
- Back-pressure:
  - Stimulus: out_ready = 0 for 10 cycles in DONE, with in_valid pulsed.
  - Required: b and out_valid stable, in_ready = 0, the second vector accepted only after the handshake.
- Reset mid-run:
  - Stimulus: assert rst at edge 2 of RUN.
  - Required: IDLE next cycle, b = 0, and a subsequent impulse transform still yields all 1.
